// File: rtl/spp_ctrl.sv
// spp_ctrl: SPP stage sequencer, CBS1 -> max-pool 5/9/13 -> CBS2.
// Packs CBS1 and pooled maps into the 4-slot concat buffer; per-stage timeout.
module spp_ctrl #(
    parameter int SLOT_WORDS = 4,
    parameter int ADDR_W     = 4,
    parameter int TIMEOUT    = 1024,
    parameter int TO_W       = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cbs1_done,
    input  logic              pool_done,
    input  logic              cbs2_done,
    input  logic              res_valid,
    output logic              cbs1_start,
    output logic              pool_start,
    output logic [1:0]        pool_sel,
    output logic              cbs2_start,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        stage
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        C1   = 3'd1,
        P5   = 3'd2,
        P9   = 3'd3,
        P13  = 3'd4,
        C2   = 3'd5,
        FIN  = 3'd6,
        ERR  = 3'd7
    } state_t;

    localparam logic [ADDR_W-1:0] FULL   = ADDR_W'(SLOT_WORDS);
    localparam logic [TO_W-1:0]   TO_LIM = TO_W'(TIMEOUT);

    state_t              state;
    state_t              nxt;
    state_t              succ;
    logic [ADDR_W-1:0]   cnt;
    logic [ADDR_W-1:0]   cnt_n;
    logic [TO_W-1:0]     tmo;
    logic [TO_W-1:0]     tmo_n;
    logic                first;
    logic                unit_done;
    logic                we;
    logic [1:0]          slot;

    // The launch pulse marks the first cycle of a state; done is ignored then.
    assign first     = cbs1_start | pool_start | cbs2_start;
    assign unit_done = (state == C1) ? cbs1_done : pool_done;
    assign slot      = state[1:0] - 2'd1;
    assign buf_we    = we;
    assign buf_addr  = we ? (ADDR_W'(slot) * FULL + cnt) : '0;
    assign busy      = (state >= C1) && (state <= C2);
    assign stage     = state;

    always_comb begin
        nxt   = state;
        cnt_n = cnt;
        tmo_n = tmo + 1'b1;
        we    = 1'b0;
        case (state)
            C1:      succ = P5;
            P5:      succ = P9;
            P9:      succ = P13;
            P13:     succ = C2;
            default: succ = IDLE;
        endcase
        case (state)
            IDLE: begin
                if (start) nxt = C1;
            end
            C1, P5, P9, P13: begin
                if (res_valid) tmo_n = '0;
                if (res_valid && cnt == FULL) begin
                    nxt = ERR;
                end else begin
                    if (res_valid) begin
                        we    = 1'b1;
                        cnt_n = cnt + 1'b1;
                    end
                    // A write in the done cycle is counted before judging.
                    if (unit_done && !first)
                        nxt = (cnt_n == FULL) ? succ : ERR;
                    else if (tmo_n == TO_LIM)
                        nxt = ERR;
                end
            end
            C2: begin
                if (cbs2_done && !first) nxt = FIN;
                else if (tmo_n == TO_LIM) nxt = ERR;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            tmo        <= '0;
            cbs1_start <= 1'b0;
            pool_start <= 1'b0;
            cbs2_start <= 1'b0;
            pool_sel   <= 2'd0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= nxt;
            cbs1_start <= (nxt == C1) && (state != C1);
            pool_start <= (nxt inside {P5, P9, P13}) && (nxt != state);
            cbs2_start <= (nxt == C2) && (state != C2);
            done       <= (nxt == FIN);
            pool_sel   <= (nxt == P9) ? 2'd1 : (nxt == P13) ? 2'd2 : 2'd0;
            if (nxt != state) begin
                cnt <= '0;
                tmo <= '0;
            end else begin
                cnt <= cnt_n;
                tmo <= tmo_n;
            end
            if (nxt == ERR)
                err <= 1'b1;
            else if (state == IDLE && start)
                err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spp_ctrl.sv
// tb_spp_ctrl: scoreboard bench for spp_ctrl.
// Expected buffer writes are queued as words are driven and popped on buf_we.
module tb_spp_ctrl;

    localparam int SW = 4;
    localparam int AW = 4;
    localparam int TO = 1024;
    localparam int TW = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          cbs1_done = 1'b0;
    logic          pool_done = 1'b0;
    logic          cbs2_done = 1'b0;
    logic          res_valid = 1'b0;
    logic          cbs1_start;
    logic          pool_start;
    logic [1:0]    pool_sel;
    logic          cbs2_start;
    logic          buf_we;
    logic [AW-1:0] buf_addr;
    logic          busy;
    logic          done;
    logic          err;
    logic [2:0]    stage;

    spp_ctrl #(
        .SLOT_WORDS(SW),
        .ADDR_W(AW),
        .TIMEOUT(TO),
        .TO_W(TW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .cbs1_done(cbs1_done),
        .pool_done(pool_done),
        .cbs2_done(cbs2_done),
        .res_valid(res_valid),
        .cbs1_start(cbs1_start),
        .pool_start(pool_start),
        .pool_sel(pool_sel),
        .cbs2_start(cbs2_start),
        .buf_we(buf_we),
        .buf_addr(buf_addr),
        .busy(busy),
        .done(done),
        .err(err),
        .stage(stage)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [1:0]    sel;
    } exp_t;

    exp_t sbq[$];
    int   pass_cnt = 0;
    int   total = 0;
    int   n_c1 = 0;
    int   n_p = 0;
    int   n_c2 = 0;
    int   n_done = 0;

    always begin : monitor
        exp_t e;
        @(negedge clk);
        #2;
        if (cbs1_start) n_c1++;
        if (pool_start) n_p++;
        if (cbs2_start) n_c2++;
        if (done) n_done++;
        if (buf_we) begin
            total++;
            if (sbq.size() == 0) begin
                $display("FAIL unexpected_write addr=%0d sel=%0d", buf_addr, pool_sel);
            end else begin
                e = sbq.pop_front();
                if ({buf_addr, pool_sel} !== {e.addr, e.sel})
                    $display("FAIL write addr=%0d sel=%0d expected addr=%0d sel=%0d",
                             buf_addr, pool_sel, e.addr, e.sel);
                else
                    pass_cnt++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic set_done(input int slot, input logic v);
        if (slot == 0) cbs1_done = v;
        else pool_done = v;
    endtask

    task automatic clr_counts();
        n_c1 = 0;
        n_p = 0;
        n_c2 = 0;
        n_done = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        res_valid = 1'b0;
        cbs1_done = 1'b0;
        pool_done = 1'b0;
        cbs2_done = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #3;
        clr_counts();
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    // Streams n words into a slot; leaves us in the next state's first cycle.
    task automatic feed(input int slot, input int n, input bit done_last,
                        input logic [1:0] sel);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            res_valid = 1'b1;
            sbq.push_back('{addr: AW'(slot * SW + i), sel: sel});
            if (done_last && i == n - 1) set_done(slot, 1'b1);
        end
        @(negedge clk);
        res_valid = 1'b0;
        set_done(slot, 1'b0);
        if (!done_last) begin
            set_done(slot, 1'b1);
            @(negedge clk);
            set_done(slot, 1'b0);
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({busy, stage, err, done} !== 6'd0)
            $display("FAIL reset_state busy=%0b stage=%0d err=%0b done=%0b expected 0",
                     busy, stage, err, done);
        else pass_cnt++;
        total++;
        if ({buf_we, buf_addr, pool_sel} !== 7'd0)
            $display("FAIL reset_buf we=%0b addr=%0d sel=%0d expected 0",
                     buf_we, buf_addr, pool_sel);
        else pass_cnt++;
        total++;
        if ({cbs1_start, pool_start, cbs2_start} !== 3'd0)
            $display("FAIL reset_starts got=%b expected 000",
                     {cbs1_start, pool_start, cbs2_start});
        else pass_cnt++;
        reset = 1'b1;
        clr_counts();
    endtask

    task automatic test_nominal();
        do_start();
        total++;
        if ({cbs1_start, busy, stage} !== {2'b11, 3'd1})
            $display("FAIL nom_c1_entry c1s=%0b busy=%0b stage=%0d expected 1 1 1",
                     cbs1_start, busy, stage);
        else pass_cnt++;
        feed(0, SW, 1'b0, 2'd0);
        total++;
        if ({pool_start, pool_sel, stage} !== {1'b1, 2'd0, 3'd2})
            $display("FAIL nom_p5_entry ps=%0b sel=%0d stage=%0d expected 1 0 2",
                     pool_start, pool_sel, stage);
        else pass_cnt++;
        feed(1, SW, 1'b0, 2'd0);
        total++;
        if ({pool_start, pool_sel, stage} !== {1'b1, 2'd1, 3'd3})
            $display("FAIL nom_p9_entry ps=%0b sel=%0d stage=%0d expected 1 1 3",
                     pool_start, pool_sel, stage);
        else pass_cnt++;
        feed(2, SW, 1'b0, 2'd1);
        total++;
        if ({pool_start, pool_sel, stage} !== {1'b1, 2'd2, 3'd4})
            $display("FAIL nom_p13_entry ps=%0b sel=%0d stage=%0d expected 1 2 4",
                     pool_start, pool_sel, stage);
        else pass_cnt++;
        feed(3, SW, 1'b0, 2'd2);
        total++;
        if ({cbs2_start, pool_sel, stage} !== {1'b1, 2'd0, 3'd5})
            $display("FAIL nom_c2_entry c2s=%0b sel=%0d stage=%0d expected 1 0 5",
                     cbs2_start, pool_sel, stage);
        else pass_cnt++;
        @(negedge clk);
        cbs2_done = 1'b1;
        @(negedge clk);
        cbs2_done = 1'b0;
        #1;
        total++;
        if ({done, busy, stage, err} !== {2'b10, 3'd6, 1'b0})
            $display("FAIL nom_fin done=%0b busy=%0b stage=%0d err=%0b expected 1 0 6 0",
                     done, busy, stage, err);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total++;
        if ({done, stage} !== 4'd0)
            $display("FAIL nom_idle done=%0b stage=%0d expected 0 0", done, stage);
        else pass_cnt++;
        total++;
        if ({sbq.size(), n_c1, n_p, n_c2, n_done} !== {32'd0, 32'd1, 32'd3, 32'd1, 32'd1})
            $display("FAIL nom_counts left=%0d c1=%0d p=%0d c2=%0d done=%0d expected 0 1 3 1 1",
                     sbq.size(), n_c1, n_p, n_c2, n_done);
        else pass_cnt++;
        clr_counts();
    endtask

    task automatic test_pool_short();
        do_start();
        feed(0, SW, 1'b0, 2'd0);
        feed(1, SW, 1'b0, 2'd0);
        feed(2, 2, 1'b0, 2'd1);
        total++;
        if ({stage, err, busy} !== {3'd7, 2'b10})
            $display("FAIL short_err stage=%0d err=%0b busy=%0b expected 7 1 0",
                     stage, err, busy);
        else pass_cnt++;
        repeat (5) @(negedge clk);
        #3;
        total++;
        if ({stage, err, n_c2, n_done} !== {3'd0, 1'b1, 32'd0, 32'd0})
            $display("FAIL short_after stage=%0d err=%0b c2=%0d done=%0d expected 0 1 0 0",
                     stage, err, n_c2, n_done);
        else pass_cnt++;
        do_start();
        total++;
        if ({err, cbs1_start} !== 2'b01)
            $display("FAIL short_restart err=%0b c1s=%0b expected 0 1", err, cbs1_start);
        else pass_cnt++;
        do_reset();
    endtask

    task automatic test_start_held();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (cbs1_start !== 1'b1)
            $display("FAIL held_c1s got=%0b expected 1", cbs1_start);
        else pass_cnt++;
        feed(0, SW, 1'b0, 2'd0);
        feed(1, SW, 1'b0, 2'd0);
        feed(2, SW, 1'b0, 2'd1);
        feed(3, SW, 1'b0, 2'd2);
        @(negedge clk);
        cbs2_done = 1'b1;
        @(negedge clk);
        cbs2_done = 1'b0;
        #1;
        total++;
        if (done !== 1'b1)
            $display("FAIL held_done got=%0b expected 1", done);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total++;
        if ({stage, n_c1, n_p, n_c2} !== {3'd0, 32'd1, 32'd3, 32'd1})
            $display("FAIL held_counts stage=%0d c1=%0d p=%0d c2=%0d expected 0 1 3 1",
                     stage, n_c1, n_p, n_c2);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total++;
        if ({stage, cbs1_start} !== {3'd1, 1'b1})
            $display("FAIL held_rerun stage=%0d c1s=%0b expected 1 1", stage, cbs1_start);
        else pass_cnt++;
        start = 1'b0;
        do_reset();
    endtask

    task automatic test_reset_mid();
        do_start();
        feed(0, SW, 1'b0, 2'd0);
        feed(1, SW, 1'b0, 2'd0);
        @(negedge clk);
        res_valid = 1'b1;
        sbq.push_back('{addr: AW'(2 * SW), sel: 2'd1});
        @(negedge clk);
        res_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        res_valid = 1'b1;
        #1;
        total++;
        if ({busy, stage, buf_we} !== 5'd0)
            $display("FAIL mid_reset busy=%0b stage=%0d we=%0b expected 0 0 0",
                     busy, stage, buf_we);
        else pass_cnt++;
        @(negedge clk);
        res_valid = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        total++;
        if (n_done !== 0)
            $display("FAIL mid_nodone got=%0d expected 0", n_done);
        else pass_cnt++;
        do_start();
        feed(0, SW, 1'b0, 2'd0);
        total++;
        if ({pool_start, sbq.size()} !== {1'b1, 32'd0})
            $display("FAIL mid_restart ps=%0b left=%0d expected 1 0", pool_start, sbq.size());
        else pass_cnt++;
        do_reset();
    endtask

    task automatic test_timeout();
        do_start();
        feed(0, SW, 1'b0, 2'd0);
        feed(1, SW, 1'b0, 2'd0);
        feed(2, SW, 1'b0, 2'd1);
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            #1;
            if (i == TO - 1) begin
                total++;
                if (stage !== 3'd4)
                    $display("FAIL to_before stage=%0d expected 4", stage);
                else pass_cnt++;
            end
        end
        total++;
        if ({stage, err} !== {3'd7, 1'b1})
            $display("FAIL to_err stage=%0d err=%0b expected 7 1", stage, err);
        else pass_cnt++;
        do_reset();
    endtask

    task automatic test_same_cycle();
        do_start();
        feed(0, SW, 1'b1, 2'd0);
        total++;
        if ({pool_start, stage, err} !== {1'b1, 3'd2, 1'b0})
            $display("FAIL same_p5 ps=%0b stage=%0d err=%0b expected 1 2 0",
                     pool_start, stage, err);
        else pass_cnt++;
        @(negedge clk);
        #3;
        total++;
        if (sbq.size() !== 0)
            $display("FAIL same_left got=%0d expected 0", sbq.size());
        else pass_cnt++;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_pool_short();
        test_start_held();
        test_reset_mid();
        test_timeout();
        test_same_cycle();
        repeat (2) @(negedge clk);
        #3;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
